io_irq_ctrl: RTL and testbench
==============================

# io_irq_ctrl

Memory-mapped I/O and interrupt controller between the processor and the data memory inside the CPU wrapper. Decodes I/O word addresses, owns the output register, and suppresses memory writes to I/O space. Selects memory or I/O data on loads, compensating for the memory's one-cycle read latency. Detects changes on the external input, holds a pending interrupt, and drives it to the processor until software acknowledges it.

## Interface
Parameters:
- NBITS, 8: data width; word address is NBITS-1:2
- OUT_ADDR, all ones (word): output register, write-only
- IN_ADDR, all ones minus 1: input snapshot, read; reading acknowledges the interrupt
- STAT_ADDR, all ones minus 2: status register, read; write sets mask when compiled in

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- memAddress  in  NBITS-2  processor word address
- memWriteData  in  NBITS  processor store data
- memMemWrite  in  1  processor store strobe
- memRead  in  1  processor load strobe (high during the load's address cycle)
- ReadData  in  NBITS  memory q, valid one cycle after address
- memWren  out  1  write enable to memory = memMemWrite and not io
- memReadData  out  NBITS  load data returned to processor
- entrada  in  NBITS  external input, already synchronous to clock
- saida  out  NBITS  output register
- interrupt  out  1  interrupt request to processor, registered

## Operation
- io = memAddress in {OUT_ADDR, IN_ADDR, STAT_ADDR}; combinational.
- Store to OUT_ADDR: saida <= memWriteData. Stores to IN_ADDR are ignored. Stores to any I/O address never reach memory.
- Load select: at each edge with memRead=1, register sel_q as one of MEM, IN, or STAT. A load from OUT_ADDR returns saida (sel_q=OUT). With memRead=0, sel_q = NONE.
- memReadData is a combinational mux on sel_q:
  - MEM: ReadData
  - IN: snap
  - OUT: saida
  - STAT: {zeros, mask, overrun, pending}, with pending as bit 0
  - NONE: 0
- Change detection:
  - prev <= entrada every cycle; change = (entrada != prev).
  - On change: snap <= entrada.
- Interrupt FSM, 2 states:
  - IDLE to PEND on change.
  - PEND to IDLE on ack (memRead=1 and memAddress=IN_ADDR), provided there is no change in the same cycle.
  - Change while in PEND: stay in PEND, update snap, set overrun.
  - Change and ack in the same cycle: stay in PEND, update snap, overrun unchanged (the new event is not lost).
- overrun: sticky; cleared only by ack or reset.
- interrupt <= (next state == PEND) and mask.
- pending in status = state == PEND, regardless of mask.

## Timing
- Reset values:
  - saida=0, interrupt=0, state=IDLE, overrun=0, snap=0, sel_q=NONE
  - prev <= entrada, so no spurious change is seen after reset
  - mask=1
- Reset mid-PEND drops the pending event; it is not re-raised.
- Change in cycle t: interrupt is high from cycle t+1.
- Ack issued in cycle t: interrupt is low from t+1. The load data (snap as of the end of t) appears on memReadData in t+1.
- Store to OUT_ADDR in cycle t: saida is updated from t+1.
- memWren is combinational, same cycle as memMemWrite.
- A load and a change in the same cycle: snap updates at the edge, so the load returns the new value.
- Back-to-back loads: each sel_q covers exactly one cycle.

## Configuration
- IO_IRQ_MASK_EN defined:
  - store to STAT_ADDR sets mask <= memWriteData[2]
  - interrupt is gated by mask
  - pending and overrun still track events while masked
  - unmasking with pending=1 asserts interrupt on the next cycle
- Undefined:
  - mask is constant 1 and reads as 1
  - stores to STAT_ADDR are ignored
  - no mask flop is synthesized

## Test plan
- Reset with entrada=8'h5A held: interrupt stays 0 for 10 cycles; STAT reads 8'h04.
- entrada 8'h00 to 8'h01 at cycle t: interrupt=1 at t+1. Load IN_ADDR: data 8'h01 returned next cycle, interrupt=0 after.
- Two changes (8'h01, then 8'h03) before ack: STAT reads 8'h07. Ack returns 8'h03; STAT then reads 8'h04.
- Change in the same cycle as ack: interrupt remains 1, snap holds the new value, overrun=0.
- Store 8'hC3 to OUT_ADDR: saida=8'hC3 next cycle, memWren=0. Store to a memory address: memWren=1, and a later load returns memory data after one cycle.
- With IO_IRQ_MASK_EN: write 0 to STAT, then change input → interrupt=0 and pending=1. Write 8'h04 → interrupt=1 on the next cycle.

Source files
------------

// File: rtl/io_irq_ctrl.sv
// Memory-mapped I/O and interrupt controller: I/O address decode, output register, load-data select,
// input change detection with pending/overrun interrupt. Define IO_IRQ_MASK_EN to add a writable interrupt mask.
module io_irq_ctrl #(
    parameter int NBITS = 8,
    parameter logic [NBITS-3:0] OUT_ADDR  = {(NBITS-2){1'b1}},
    parameter logic [NBITS-3:0] IN_ADDR   = {{(NBITS-3){1'b1}}, 1'b0},
    parameter logic [NBITS-3:0] STAT_ADDR = {{(NBITS-4){1'b1}}, 2'b01}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-3:0] memAddress,
    input  logic [NBITS-1:0] memWriteData,
    input  logic             memMemWrite,
    input  logic             memRead,
    input  logic [NBITS-1:0] ReadData,
    output logic             memWren,
    output logic [NBITS-1:0] memReadData,
    input  logic [NBITS-1:0] entrada,
    output logic [NBITS-1:0] saida,
    output logic             interrupt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_MEM  = 3'd1;
    localparam logic [2:0] SEL_IN   = 3'd2;
    localparam logic [2:0] SEL_OUT  = 3'd3;
    localparam logic [2:0] SEL_STAT = 3'd4;

    logic             is_out, is_in, is_stat, io;
    logic             change, ack;
    logic [0:0]       state_reg, state_next;
    logic             overrun_reg;
    logic             interrupt_reg;
    logic [NBITS-1:0] prev_reg, snap_reg, saida_reg;
    logic [2:0]       sel_reg, sel_next;
    logic             mask_reg, mask_next;

    assign is_out  = (memAddress == OUT_ADDR);
    assign is_in   = (memAddress == IN_ADDR);
    assign is_stat = (memAddress == STAT_ADDR);
    assign io      = is_out | is_in | is_stat;
    assign memWren = memMemWrite & ~io;

    assign change = (entrada != prev_reg);
    assign ack    = memRead & is_in;

`ifdef IO_IRQ_MASK_EN
    always_comb begin
        mask_next = mask_reg;
        if (memMemWrite && is_stat) begin
            mask_next = memWriteData[2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_reg <= 1'b1;
        end else begin
            mask_reg <= mask_next;
        end
    end
`else
    assign mask_reg  = 1'b1;
    assign mask_next = 1'b1;
`endif

    // A change always wins over an ack so a new event arriving with the ack is kept pending.
    always_comb begin
        state_next = state_reg;
        if (change) begin
            state_next = PEND;
        end else if (ack) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        sel_next = SEL_NONE;
        if (memRead) begin
            if (is_in) begin
                sel_next = SEL_IN;
            end else if (is_out) begin
                sel_next = SEL_OUT;
            end else if (is_stat) begin
                sel_next = SEL_STAT;
            end else begin
                sel_next = SEL_MEM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_reg      <= entrada;
            snap_reg      <= '0;
            saida_reg     <= '0;
            state_reg     <= IDLE;
            overrun_reg   <= 1'b0;
            interrupt_reg <= 1'b0;
            sel_reg       <= SEL_NONE;
        end else begin
            prev_reg      <= entrada;
            sel_reg       <= sel_next;
            state_reg     <= state_next;
            interrupt_reg <= (state_next == PEND) && mask_next;
            if (change) begin
                snap_reg <= entrada;
            end
            if (memMemWrite && is_out) begin
                saida_reg <= memWriteData;
            end
            if (ack && !change) begin
                overrun_reg <= 1'b0;
            end else if (change && !ack && (state_reg == PEND)) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Memory q arrives one cycle after the address, so the mux follows the registered select.
    always_comb begin
        memReadData = '0;
        case (sel_reg)
            SEL_MEM:  memReadData = ReadData;
            SEL_IN:   memReadData = snap_reg;
            SEL_OUT:  memReadData = saida_reg;
            SEL_STAT: memReadData = {{(NBITS-3){1'b0}}, mask_reg, overrun_reg, (state_reg == PEND)};
            default:  memReadData = '0;
        endcase
    end

    assign saida     = saida_reg;
    assign interrupt = interrupt_reg;
endmodule

// File: tb/tb_io_irq_ctrl.sv
// Bench for io_irq_ctrl: directed literal checks plus randomized traffic against an event-level model.
module tb_io_irq_ctrl;
    localparam logic [5:0] OUT_A  = 6'd63;
    localparam logic [5:0] IN_A   = 6'd62;
    localparam logic [5:0] STAT_A = 6'd61;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_write;
    logic       mem_read;
    logic [7:0] read_data;
    logic       mem_wren;
    logic [7:0] mem_read_data;
    logic [7:0] entrada;
    logic [7:0] saida;
    logic       interrupt;

    int n_checks = 0;
    int n_fail   = 0;

    io_irq_ctrl #(.NBITS(8)) dut (
        .clock(clock), .reset(reset), .memAddress(mem_address), .memWriteData(mem_write_data),
        .memMemWrite(mem_write), .memRead(mem_read), .ReadData(read_data), .memWren(mem_wren),
        .memReadData(mem_read_data), .entrada(entrada), .saida(saida), .interrupt(interrupt)
    );

    always #5 clock = ~clock;

    // Data memory behind the controller: one-cycle registered read.
    logic [7:0] ram [0:63];
    logic [7:0] shadow [0:63];
    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i]    = 8'(i * 37 + 11);
            shadow[i] = 8'(i * 37 + 11);
        end
    end
    always @(posedge clock) begin
        if (mem_wren) ram[mem_address] <= mem_write_data;
        read_data <= ram[mem_address];
    end

    // Event-level model: pending flag, overrun flag, last captured input, output register, mask.
    logic       m_valid = 1'b0;
    logic [7:0] m_prev, m_snap, m_saida, m_load;
    logic       m_pend, m_ovr, m_mask, m_int;
    int         m_sel;   // 0 none, 1 memory, 2 input, 3 output, 4 status
    logic       chg_c, ack_c, io_c, mask_n, pend_n;

    assign io_c   = (mem_address == OUT_A) || (mem_address == IN_A) || (mem_address == STAT_A);
    assign chg_c  = (entrada != m_prev);
    assign ack_c  = mem_read && (mem_address == IN_A);
    assign pend_n = chg_c ? 1'b1 : (ack_c ? 1'b0 : m_pend);
`ifdef IO_IRQ_MASK_EN
    assign mask_n = (mem_write && mem_address == STAT_A) ? mem_write_data[2] : m_mask;
`else
    assign mask_n = 1'b1;
`endif

    always @(posedge clock) begin
        m_valid <= 1'b1;
        if (reset) begin
            m_prev <= entrada; m_snap <= 8'h00; m_saida <= 8'h00;
            m_pend <= 1'b0; m_ovr <= 1'b0; m_mask <= 1'b1; m_int <= 1'b0; m_sel <= 0;
        end else begin
            m_prev <= entrada;
            if (chg_c) m_snap <= entrada;
            m_pend <= pend_n;
            m_mask <= mask_n;
            m_int  <= pend_n && mask_n;
            if (ack_c && !chg_c) m_ovr <= 1'b0;
            else if (chg_c && !ack_c && m_pend) m_ovr <= 1'b1;
            if (mem_write && mem_address == OUT_A) m_saida <= mem_write_data;
            if (mem_write && !io_c) shadow[mem_address] <= mem_write_data;
            m_load <= shadow[mem_address];
            if (!mem_read) m_sel <= 0;
            else if (mem_address == IN_A) m_sel <= 2;
            else if (mem_address == OUT_A) m_sel <= 3;
            else if (mem_address == STAT_A) m_sel <= 4;
            else m_sel <= 1;
        end
    end

    function automatic logic [7:0] exp_read();
        case (m_sel)
            1: return m_load;
            2: return m_snap;
            3: return m_saida;
            4: return {5'b0, m_mask, m_ovr, m_pend};
            default: return 8'h00;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            check("memWren", 8'(mem_wren), 8'(mem_write && !io_c));
            check("interrupt", 8'(interrupt), 8'(m_int));
            check("saida", saida, m_saida);
            check("memReadData", mem_read_data, exp_read());
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic load(input logic [5:0] a);
        mem_address = a; mem_read = 1'b1; tick(); mem_read = 1'b0;
    endtask

    task automatic store(input logic [5:0] a, input logic [7:0] d);
        mem_address = a; mem_write_data = d; mem_write = 1'b1; tick(); mem_write = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_address = 6'd0; mem_write_data = 8'h00; mem_write = 1'b0;
        mem_read = 1'b0; entrada = 8'h5A;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("quiet_after_reset", 8'(interrupt), 8'h00);
        end
        load(STAT_A);  check("stat_reset", mem_read_data, 8'h04);

        entrada = 8'h00; tick();  check("irq_first", 8'(interrupt), 8'h01);
        load(IN_A);  check("ack_data0", mem_read_data, 8'h00);
        check("ack_irq0", 8'(interrupt), 8'h00);
        tick();
        entrada = 8'h01; tick();  check("irq_rise", 8'(interrupt), 8'h01);
        load(IN_A);  check("ack_data1", mem_read_data, 8'h01);
        check("ack_irq1", 8'(interrupt), 8'h00);

        entrada = 8'h00; tick();
        entrada = 8'h03; tick();
        load(STAT_A);  check("stat_overrun", mem_read_data, 8'h07);
        load(IN_A);    check("ack_data3", mem_read_data, 8'h03);
        load(STAT_A);  check("stat_cleared", mem_read_data, 8'h04);

        entrada = 8'h05; tick();
        entrada = 8'h06; load(IN_A);
        check("ack_change_irq", 8'(interrupt), 8'h01);
        check("ack_change_data", mem_read_data, 8'h06);
        load(STAT_A);  check("ack_change_stat", mem_read_data, 8'h05);
        load(IN_A);    check("final_ack", mem_read_data, 8'h06);

        mem_address = OUT_A; mem_write_data = 8'hC3; mem_write = 1'b1; #1;
        check("io_wren", 8'(mem_wren), 8'h00);
        tick(); mem_write = 1'b0;
        check("saida_c3", saida, 8'hC3);
        mem_address = 6'd5; mem_write_data = 8'h3C; mem_write = 1'b1; #1;
        check("mem_wren", 8'(mem_wren), 8'h01);
        tick(); mem_write = 1'b0;
        load(6'd5);   check("mem_load", mem_read_data, 8'h3C);
        load(OUT_A);  check("out_load", mem_read_data, 8'hC3);
        tick();       check("no_load", mem_read_data, 8'h00);

`ifdef IO_IRQ_MASK_EN
        store(STAT_A, 8'h00);
        entrada = 8'h07; tick();  check("masked_irq", 8'(interrupt), 8'h00);
        load(STAT_A);  check("masked_stat", mem_read_data, 8'h01);
        store(STAT_A, 8'h04);  check("unmask_irq", 8'(interrupt), 8'h01);
        load(IN_A);    check("masked_data", mem_read_data, 8'h07);
`endif

        for (int n = 0; n < 3000; n++) begin
            int op;
            reset = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 1) == 1) mem_address = 6'(61 + $urandom_range(0, 2));
            else mem_address = 6'($urandom_range(0, 7));
            op = $urandom_range(0, 3);
            mem_read  = (op == 1);
            mem_write = (op == 2);
            mem_write_data = 8'($urandom);
            if ($urandom_range(0, 9) < 3) entrada = 8'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
